// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined LSL/LSR/ASR/ROR barrel shifter, one register stage per shift-amount bit.
// Define BSHIFT_ROTATE_EN to make op 11 rotate right; otherwise op 11 passes data unchanged.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);
    logic [SHAMT_W-1:0] vld, rdy, pv;
    logic [WIDTH-1:0]   dat [SHAMT_W];
    logic [1:0]         opr [SHAMT_W];
    logic [SHAMT_W-1:0] amt [SHAMT_W];
    logic [WIDTH-1:0]   pd  [SHAMT_W];
    logic [WIDTH-1:0]   nd  [SHAMT_W];
    logic [1:0]         po  [SHAMT_W];
    logic [SHAMT_W-1:0] pa  [SHAMT_W];
    logic               chain;
    logic               zero_q;

    // Ready ripples back from the sink; an empty stage is always ready.
    always_comb begin
        chain = out_ready;
        rdy = '0;
        for (int s = SHAMT_W - 1; s >= 0; s--) begin
            chain = !vld[s] || chain;
            rdy[s] = chain;
        end
    end

    for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
        localparam int K = 1 << g;
        logic [WIDTH-1:0] rr;
        if (g == 0) begin : g_first
            assign pv[g] = in_valid;
            assign pd[g] = in_data;
            assign po[g] = in_op;
            assign pa[g] = in_shamt;
        end else begin : g_next
            assign pv[g] = vld[g-1];
            assign pd[g] = dat[g-1];
            assign po[g] = opr[g-1];
            assign pa[g] = amt[g-1];
        end
`ifdef BSHIFT_ROTATE_EN
        assign rr = {pd[g][K-1:0], pd[g][WIDTH-1:K]};
`else
        assign rr = pd[g];
`endif
        // ASR copies the current MSB, which every earlier stage has preserved as the sign.
        assign nd[g] = !pa[g][g]      ? pd[g] :
                       po[g] == 2'b00 ? {pd[g][WIDTH-K-1:0], {K{1'b0}}} :
                       po[g] == 2'b01 ? {{K{1'b0}}, pd[g][WIDTH-1:K]} :
                       po[g] == 2'b10 ? {{K{pd[g][WIDTH-1]}}, pd[g][WIDTH-1:K]} : rr;
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < SHAMT_W; s++) begin
            if (!rst_n) vld[s] <= 1'b0;
            else if (rdy[s]) vld[s] <= pv[s];
            if (rst_n && rdy[s] && pv[s]) begin
                dat[s] <= nd[s];
                opr[s] <= po[s];
                amt[s] <= pa[s];
            end
        end
        if (!rst_n) begin
            dat[SHAMT_W-1] <= '0;
            zero_q <= 1'b0;
        end else if (rdy[SHAMT_W-1] && pv[SHAMT_W-1]) begin
            zero_q <= nd[SHAMT_W-1] == '0;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[SHAMT_W-1];
    assign out_data  = dat[SHAMT_W-1];
    assign out_zero  = zero_q;
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed-vector bench for the 8-bit pipelined barrel shifter.
module tb_barrel_shifter_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_shamt = '0;
    logic [1:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_zero;
    int checks = 0;
    int failures = 0;

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    localparam int N = 10;
`ifdef BSHIFT_ROTATE_EN
    localparam logic [7:0] ROR_B3 = 8'h76;
    localparam logic [7:0] ROR_01 = 8'h80;
`else
    localparam logic [7:0] ROR_B3 = 8'hB3;
    localparam logic [7:0] ROR_01 = 8'h01;
`endif
    localparam logic [7:0] VD [N] = '{8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'h01, 8'h80, 8'h0F, 8'h0F, 8'h80, 8'h01};
    localparam logic [2:0] VS [N] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd7, 3'd4, 3'd4, 3'd7, 3'd1};
    localparam logic [1:0] VO [N] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    localparam logic [7:0] VE [N] = '{8'h98, 8'h16, 8'hF6, ROR_B3, 8'h01, 8'h01, 8'hF0, 8'h00, 8'hFF, ROR_01};
    localparam logic       VZ [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic set_vec(input int i);
        in_data  = VD[i];
        in_shamt = VS[i];
        in_op    = VO[i];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
    endtask

    task automatic test_ops;
        int nin = 0;
        int nout = 0;
        int acc [N];
        out_ready = 1'b1;
        for (int c = 0; c < 40 && nout < N; c++) begin
            @(negedge clk);
            in_valid = nin < N;
            if (nin < N) set_vec(nin);
            #1;
            if (out_valid) begin
                checks++; if (out_data !== VE[nout]) begin failures++; $display("FAIL ops_data[%0d] got=%h exp=%h", nout, out_data, VE[nout]); end
                checks++; if (out_zero !== VZ[nout]) begin failures++; $display("FAIL ops_zero[%0d] got=%b exp=%b", nout, out_zero, VZ[nout]); end
                checks++; if (c - acc[nout] != 3) begin failures++; $display("FAIL ops_latency[%0d] got=%0d exp=3", nout, c - acc[nout]); end
                nout++;
            end
            if (in_valid && in_ready) begin
                acc[nin] = c;
                nin++;
            end
        end
        in_valid = 1'b0;
        checks++; if (nout != N) begin failures++; $display("FAIL ops_count got=%0d exp=%0d", nout, N); end
    endtask

    task automatic test_backpressure;
        int nin = 0;
        int nout = 0;
        logic held = 1'b0;
        logic saw_stall = 1'b0;
        logic [7:0] held_d = '0;
        for (int c = 0; c < 60 && nout < 6; c++) begin
            @(negedge clk);
            in_valid = nin < 6;
            if (nin < 6) set_vec(nin);
            out_ready = !(c >= 2 && c < 7);
            #1;
            if (held) begin
                checks++; if (out_valid !== 1'b1 || out_data !== held_d) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, out_data, held_d); end
            end
            if (!in_ready) begin
                saw_stall = 1'b1;
                checks++; if (nin - nout != 3) begin failures++; $display("FAIL bp_occupancy got=%0d exp=3", nin - nout); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_data !== VE[nout]) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", nout, out_data, VE[nout]); end
                nout++;
            end
            held = out_valid && !out_ready;
            held_d = out_data;
            if (in_valid && in_ready) nin++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (saw_stall !== 1'b1) begin failures++; $display("FAIL bp_stall got=%b exp=1", saw_stall); end
        checks++; if (nout != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", nout); end
    endtask

    task automatic test_reset_flush;
        int acc = -1;
        int nout = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            set_vec(c);
        end
        @(negedge clk);
        rst_n = 1'b0;
        set_vec(2);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid[%0d] got=%b exp=0", c, out_valid); end
            @(negedge clk);
        end
        for (int c = 0; c < 12 && nout == 0; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = c == 0;
            set_vec(6);
            #1;
            if (out_valid) begin
                checks++; if (out_data !== 8'hF0) begin failures++; $display("FAIL flush_data got=%h exp=f0", out_data); end
                checks++; if (c - acc != 3) begin failures++; $display("FAIL flush_latency got=%0d exp=3", c - acc); end
                nout++;
            end
            if (in_valid && in_ready) acc = c;
        end
        in_valid = 1'b0;
        checks++; if (nout != 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", nout); end
    endtask

    initial begin
        test_reset;
        test_ops;
        test_backpressure;
        test_reset_flush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
